// File: rtl/log2_share_arbiter.sv
// Round-robin front end that shares one fixed-latency log2 core among NREQ clients.
// A tag pipeline, matched to the core latency, attaches the requester ID and range flag to each result.
module log2_share_arbiter #(
  parameter int NREQ    = 4,
  parameter int IDW     = 2,
  parameter int LATENCY = 3
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NREQ-1:0]      req_valid,
  input  logic [24*NREQ-1:0]   req_data,
  output logic [NREQ-1:0]      req_ready,
  output logic [23:0]          log_din,
  input  logic [11:0]          log_dout,
  output logic                 resp_valid,
  output logic [IDW-1:0]       resp_id,
  output logic [11:0]          resp_data,
  output logic                 resp_err,
  output logic                 busy
);

  logic [IDW-1:0]     r_ptr;
  logic [LATENCY-1:0] r_tag_v;
  logic [LATENCY-1:0] r_tag_err;
  logic [IDW-1:0]     r_tag_id [LATENCY];

  logic               w_found;
  logic [IDW-1:0]     w_idx;
  logic               w_grant;
  logic               w_err;

  function automatic logic [IDW-1:0] wrap_idx(input logic [IDW-1:0] base, input int off);
    int k;
    k = int'(base) + off;
    if (k >= NREQ) k -= NREQ;
    return IDW'(k);
  endfunction

  // NOTE: always_comb uses blocking assignments with defaults first, so w_found
  // reads back within the loop and nothing can be inferred as a latch.
  always_comb begin
    w_found = 1'b0;
    w_idx   = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (!w_found && req_valid[wrap_idx(r_ptr, i)]) begin
        w_found = 1'b1;
        w_idx   = wrap_idx(r_ptr, i);
      end
    end
  end

  // Reset wins over a simultaneous request, so no grant is issued while rst_n is low.
  assign w_grant   = w_found & rst_n;
  assign req_ready = w_grant ? (NREQ'(1) << w_idx) : '0;
  assign log_din   = w_grant ? req_data[24*w_idx +: 24] : '0;
  assign w_err     = (log_din < 24'h000100);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_ptr <= '0;
    end else if (w_grant) begin
      r_ptr <= (int'(w_idx) == NREQ - 1) ? '0 : w_idx + 1'b1;
    end
  end

  // NOTE: the ID and err stages are reset along with the valid bits. Their
  // contents are ignored while v is low, but the extra reset is cheap here and
  // keeps the response fields at zero after reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_tag_v    <= '0;
      r_tag_err  <= '0;
      for (int s = 0; s < LATENCY; s++) r_tag_id[s] <= '0;
      resp_valid <= 1'b0;
      resp_id    <= '0;
      resp_data  <= '0;
      resp_err   <= 1'b0;
    end else begin
      r_tag_v[0]   <= w_grant;
      r_tag_id[0]  <= w_idx;
      r_tag_err[0] <= w_err;
      for (int s = 1; s < LATENCY; s++) begin
        r_tag_v[s]   <= r_tag_v[s-1];
        r_tag_id[s]  <= r_tag_id[s-1];
        r_tag_err[s] <= r_tag_err[s-1];
      end
      resp_valid <= r_tag_v[LATENCY-1];
      resp_id    <= r_tag_id[LATENCY-1];
      resp_err   <= r_tag_v[LATENCY-1] & r_tag_err[LATENCY-1];
      resp_data  <= (r_tag_v[LATENCY-1] && !r_tag_err[LATENCY-1]) ? log_dout : '0;
    end
  end

  assign busy = (|r_tag_v) | resp_valid;

endmodule

// File: tb/tb_log2_share_arbiter.sv
// Directed bench for log2_share_arbiter. A 3-stage stand-in core returns
// hand-tabulated log2 values for the operands used below.
module tb_log2_share_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [3:0]  req_valid;
  logic [95:0] req_data;
  logic [3:0]  req_ready;
  logic [23:0] log_din;
  logic [11:0] log_dout;
  logic        resp_valid;
  logic [1:0]  resp_id;
  logic [11:0] resp_data;
  logic        resp_err;
  logic        busy;

  int n_total = 0;
  int n_bad   = 0;

  always #5 clk = ~clk;

  log2_share_arbiter dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_data   (req_data),
    .req_ready  (req_ready),
    .log_din    (log_din),
    .log_dout   (log_dout),
    .resp_valid (resp_valid),
    .resp_id    (resp_id),
    .resp_data  (resp_data),
    .resp_err   (resp_err),
    .busy       (busy)
  );

  // Stand-in log2 core: unreset, three-stage, returns log2 in iiii.ffffffff.
  function automatic logic [11:0] core_fn(input logic [23:0] d);
    case (d)
      24'h000100: return 12'h000;
      24'h000200: return 12'h100;
      24'h000400: return 12'h200;
      24'h000800: return 12'h300;
      24'hFFFFFF: return 12'hFFD;
      default:    return 12'h5A5;
    endcase
  endfunction

  logic [23:0] core_pipe [3];
  always @(posedge clk) begin
    core_pipe[0] <= log_din;
    core_pipe[1] <= core_pipe[0];
    core_pipe[2] <= core_pipe[1];
  end
  assign log_dout = core_fn(core_pipe[2]);

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_data(input int i, input logic [23:0] d);
    req_data[24*i +: 24] = d;
  endtask

  task automatic check_resp(input logic v, input logic [1:0] id, input logic [11:0] d,
                            input logic e);
    check("resp_valid", 32'(resp_valid), 32'(v));
    if (v) begin
      check("resp_id",   32'(resp_id),   32'(id));
      check("resp_data", 32'(resp_data), 32'(d));
      check("resp_err",  32'(resp_err),  32'(e));
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset held with every requester asserting: reset wins, no grant.
    rst_n     = 1'b0;
    req_valid = 4'b1111;
    req_data  = '0;
    for (int i = 0; i < 4; i++) set_data(i, 24'h000100);
    repeat (3) tick();
    #1;
    check("rst_ready",  32'(req_ready),  32'h0);
    check("rst_din",    32'(log_din),    32'h0);
    check("rst_rvalid", 32'(resp_valid), 32'h0);
    check("rst_rid",    32'(resp_id),    32'h0);
    check("rst_rdata",  32'(resp_data),  32'h0);
    check("rst_rerr",   32'(resp_err),   32'h0);
    check("rst_busy",   32'(busy),       32'h0);
    rst_n     = 1'b1;
    req_valid = 4'b0000;
    tick();

    // Single request on requester 0, latency 4, busy t+1..t+4. Pointer -> 1.
    for (int c = 0; c < 6; c++) begin
      check("t1_busy", 32'(busy), (c >= 1 && c <= 4) ? 32'h1 : 32'h0);
      check_resp(c == 4, 2'd0, 12'h000, 1'b0);
      req_valid = (c == 0) ? 4'b0001 : 4'b0000;
      #1;
      if (c == 0) begin
        check("t1_ready", 32'(req_ready), 32'h1);
        check("t1_din",   32'(log_din),   32'h000100);
      end
      tick();
    end

    // Requester 1 twice back-to-back; second wins again after wrap. Pointer -> 2.
    for (int c = 0; c < 7; c++) begin
      check_resp(c == 4 || c == 5, 2'd1, (c == 4) ? 12'h100 : 12'hFFD, 1'b0);
      req_valid = (c < 2) ? 4'b0010 : 4'b0000;
      set_data(1, (c == 0) ? 24'h000200 : 24'hFFFFFF);
      #1;
      if (c < 2) check("t2_ready", 32'(req_ready), 32'h2);
      tick();
    end

    // Out-of-range operand on requester 3. Pointer -> 0.
    set_data(3, 24'h0000FF);
    for (int c = 0; c < 6; c++) begin
      check_resp(c == 4, 2'd3, 12'h000, 1'b1);
      if (c == 5) check("t5_busy", 32'(busy), 32'h0);
      req_valid = (c == 0) ? 4'b1000 : 4'b0000;
      #1;
      if (c == 0) check("t5_ready", 32'(req_ready), 32'h8);
      tick();
    end

    // All four held for 8 cycles: grants and responses 0,1,2,3,0,1,2,3. Pointer -> 0.
    for (int i = 0; i < 4; i++) set_data(i, 24'h000100 << i);
    for (int c = 0; c < 13; c++) begin
      check_resp(c >= 4 && c < 12, 2'((c - 4) % 4), 12'(((c - 4) % 4) * 'h100), 1'b0);
      req_valid = (c < 8) ? 4'b1111 : 4'b0000;
      #1;
      if (c < 8) check("t3_ready", 32'(req_ready), 32'(1 << (c % 4)));
      tick();
    end

    // Requesters 0 and 2 held: grants alternate 0,2. Pointer -> 3.
    for (int c = 0; c < 11; c++) begin
      check_resp(c >= 4 && c < 10, 2'(((c - 4) % 2) * 2), 12'((((c - 4) % 2) * 2) * 'h100),
                 1'b0);
      req_valid = (c < 6) ? 4'b0101 : 4'b0000;
      #1;
      if (c < 6) check("t4_ready", 32'(req_ready), (c % 2 == 0) ? 32'h1 : 32'h4);
      tick();
    end

    // Three grants (3,0,1), reset two cycles later, then requesters 1..3 ask.
    // With the pointer back at 0, requester 1 must win.
    for (int c = 0; c < 15; c++) begin
      if (c >= 5 && c <= 8) begin
        check("t6_rvalid", 32'(resp_valid), 32'h0);
        check("t6_busy",   32'(busy),       32'h0);
      end
      if (c >= 10 && c <= 12) check("t6_busy_new", 32'(busy), 32'h1);
      if (c >= 10) check_resp(c == 13, 2'd1, 12'h100, 1'b0);
      rst_n     = (c == 4) ? 1'b0 : 1'b1;
      req_valid = (c < 3 || c == 4) ? 4'b1111 : (c == 9) ? 4'b1110 : 4'b0000;
      #1;
      if (c < 3) check("t6_ready", 32'(req_ready), (c == 0) ? 32'h8 : (c == 1) ? 32'h1 : 32'h2);
      if (c == 4) begin
        check("t6_rst_ready", 32'(req_ready), 32'h0);
        check("t6_rst_din",   32'(log_din),   32'h0);
      end
      if (c == 9) check("t6_after_ready", 32'(req_ready), 32'h2);
      tick();
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule

// File: doc/log2_share_arbiter.md
Name: log2_share_arbiter

Overview:
- Shares one fixed-latency, non-stallable base-2 log pipeline (24-bit in, 12-bit out, 3-cycle latency, no reset, no handshake) between NREQ requesters.
- Arbitrates requests round-robin and issues at most one operand per cycle.
- Tracks requester ID and an out-of-range flag through a tag pipeline that matches the core's latency.
- Returns each tagged result on a single response port.
- Sits between the requesting client blocks and the log2 core instance.

Parameters:
- NREQ, 4, number of requesters (2..8)
- IDW, 2, requester ID width; must equal clog2(NREQ)
- LATENCY, 3, log core latency in clocks: DOUT is valid LATENCY edges after DIN is sampled

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  synchronous active-low reset
- req_valid  in  NREQ  per-requester request valid
- req_data  in  24*NREQ  per-requester operand; requester i uses bits [24*i+23:24*i]
- req_ready  out  NREQ  one-hot grant; a handshake completes when valid and ready are both high
- log_din  out  24  operand to the log core DIN
- log_dout  in  12  result from the log core DOUT
- resp_valid  out  1  response valid, single-cycle pulse per request
- resp_id  out  IDW  requester index for the response
- resp_data  out  12  log2 result, format iiii.ffffffff
- resp_err  out  1  operand was below 0x000100 (value below 1.00)
- busy  out  1  at least one request is in flight

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-low on rst_n.
- Reset values:
  - round-robin pointer = 0
  - all tag-pipe valid bits = 0
  - resp_valid = 0, resp_id = 0, resp_data = 0, resp_err = 0
  - busy = 0
- While rst_n is low: req_ready = 0 and log_din = 0.
- Arbitration (combinational, same cycle):
  - Search req_valid starting at the pointer index, ascending with wrap-around.
  - The first set bit wins; req_ready has exactly that bit set.
  - req_ready never depends on resp state; there is no backpressure.
  - If no req_valid is set: req_ready = 0 and log_din = 0.
- Issue:
  - log_din = req_data of the granted requester, combinationally, in the same cycle as the grant.
  - The core samples it at the next rising edge.
- Pointer update on a grant edge: pointer <= granted index + 1, wrapping at NREQ. With no grant, the pointer holds.
- Tag pipeline:
  - LATENCY stages, each holding {v, id, err}.
  - Stage 0 loads {grant_any, granted_index, operand < 0x000100} at each edge.
  - Stages shift unconditionally every cycle.
- Response register, loaded every edge from the last tag stage:
  - resp_valid <= v
  - resp_id <= id
  - resp_err <= v & err
  - resp_data <= 0 if err or !v, else log_dout
- Latency: handshake in cycle t gives resp_valid high in cycle t+LATENCY+1, which is t+4 with the default.
- Throughput: one response per cycle sustained. Response order equals grant order.
- busy = OR of all tag-stage v bits and resp_valid.
- A requester that holds req_valid after its grant is re-arbitrated normally. A new handshake needs another grant cycle.
- Reset mid-operation: all in-flight tags are discarded and no response is emitted for them. The core's unreset pipeline contents are ignored because their tags are invalid.
- A request whose operand is below 0x000100 still consumes a core slot, which keeps the pipeline timing uniform. Its response has resp_err=1 and resp_data=0.
- Upper operand bit 23 with bit 22 clear is passed unchanged; the result comes from the core.
- Concurrent reset and request: reset wins; no grant.

Test Plan:
- Reset release, req_valid[0]=1 with data 0x000100 for one cycle (cycle t) -> req_ready=0001 in t; resp_valid in t+4 with resp_id=0, resp_data=0x000, resp_err=0; busy high t+1..t+4.
- req_valid[1] with data 0x000200, then next cycle 0xFFFFFF -> resp_id=1 in consecutive cycles with resp_data=0x100 then 0xFFD.
- All four req_valid held high for 8 cycles from pointer 0 -> grants cycle through 0,1,2,3,0,1,2,3; resp_id follows the same sequence from t+4 with no gaps.
- req_valid[0] and req_valid[2] held continuously -> grants alternate 0,2,0,2; requesters 1 and 3 never get ready.
- req_valid[3] with data 0x0000FF -> resp_valid in t+4 with resp_id=3, resp_err=1, resp_data=0x000.
- Three back-to-back grants, then rst_n=0 for 1 cycle two cycles after the last grant -> no resp_valid afterwards, busy=0, and the next grant goes to the lowest-index valid requester.
